// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: architectural register numbers, basic
// types and the write-register-select encoding used by the upstream mux.
package mips_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  localparam logic [2:0] SEL_RT = 3'd0;
  localparam logic [2:0] SEL_RD = 3'd1;
  localparam logic [2:0] SEL_RS = 3'd2;
  localparam logic [2:0] SEL_SP = 3'd3;
  localparam logic [2:0] SEL_RA = 3'd4;

endpackage

// File: rtl/banco_reg_mips_chk.sv
// Simulation-only checker: flags a write attempt whose address is unknown.
module banco_reg_mips_chk (
  input logic       clk,
  input logic       reset,
  input logic       reg_write,
  input logic [4:0] write_reg
);

  // Report an X/Z write address while a write is requested.
  always_ff @(posedge clk) begin
    if (reset && reg_write && $isunknown(write_reg)) begin
      $error("banco_reg_mips: RegWrite with unknown WriteReg %b", write_reg);
    end else begin
    end
  end

endmodule

// File: rtl/banco_reg_readport.sv
// One combinational register-file read port: $zero guard plus, when
// BANCO_REG_BYPASS_EN is defined, write-through forwarding of the pending write.
module banco_reg_readport
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  reg_addr_t         rd_addr,
  input  logic [DATA_W-1:0] stored_data,
`ifdef BANCO_REG_BYPASS_EN
  input  logic              wr_en,
  input  reg_addr_t         wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`endif
  output logic [DATA_W-1:0] rd_data
);

  // Select zero, forwarded write data, or the stored word.
  always_comb begin
    rd_data = stored_data;
    if (rd_addr == REG_ZERO) begin
      rd_data = '0;
`ifdef BANCO_REG_BYPASS_EN
    end else if (wr_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
`endif
    end else begin
      rd_data = stored_data;
    end
  end

endmodule

// File: rtl/banco_reg_mips.sv
// 32 x DATA_W MIPS register file with hardwired $zero and reset values for $sp/$ra.
// Optional macro BANCO_REG_BYPASS_EN enables same-cycle write-through on reads.
module banco_reg_mips
  import mips_pkg::*;
#(
  parameter int               DATA_W  = 32,
  parameter logic [DATA_W-1:0] SP_INIT = 32'd227,
  parameter logic [DATA_W-1:0] RA_INIT = 32'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  reg_addr_t         ReadReg1,
  input  reg_addr_t         ReadReg2,
  input  reg_addr_t         WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] SpOut,
  output logic [15:0]       WriteCount
);

  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] regs_d [32];
  logic [15:0]       count_q;
  logic [15:0]       count_d;
  logic              we_s;

  // An unknown address compares as X, so no write is taken for it in simulation.
  assign we_s = RegWrite && (WriteReg != REG_ZERO);

  // Next-state for storage and the committed-write counter.
  always_comb begin
    regs_d  = regs_q;
    count_d = count_q;
    if (we_s) begin
      regs_d[WriteReg] = WriteData;
      count_d          = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // State registers; synchronous reset wins over any same-edge write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[REG_SP] <= SP_INIT;
      regs_q[REG_RA] <= RA_INIT;
      count_q        <= 16'd0;
    end else begin
      regs_q  <= regs_d;
      count_q <= count_d;
    end
  end

  assign WriteCount = count_q;

  banco_reg_readport #(.DATA_W(DATA_W)) u_rd1 (
    .rd_addr     (ReadReg1),
    .stored_data (regs_q[ReadReg1]),
`ifdef BANCO_REG_BYPASS_EN
    .wr_en       (we_s),
    .wr_addr     (WriteReg),
    .wr_data     (WriteData),
`endif
    .rd_data     (ReadData1)
  );

  banco_reg_readport #(.DATA_W(DATA_W)) u_rd2 (
    .rd_addr     (ReadReg2),
    .stored_data (regs_q[ReadReg2]),
`ifdef BANCO_REG_BYPASS_EN
    .wr_en       (we_s),
    .wr_addr     (WriteReg),
    .wr_data     (WriteData),
`endif
    .rd_data     (ReadData2)
  );

`ifdef BANCO_REG_BYPASS_EN
  assign SpOut = (we_s && (WriteReg == REG_SP)) ? WriteData : regs_q[REG_SP];
`else
  assign SpOut = regs_q[REG_SP];
`endif

`ifndef SYNTHESIS
  banco_reg_mips_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .reg_write (RegWrite),
    .write_reg (WriteReg)
  );
`endif

endmodule

// File: tb/tb_banco_reg_mips.sv
// Directed, table-driven bench for banco_reg_mips with hand sequences for
// same-cycle read, reset-vs-write priority and counter wrap.
module tb_banco_reg_mips;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  ReadReg1, ReadReg2, WriteReg;
  logic [31:0] WriteData, ReadData1, ReadData2, SpOut;
  logic [15:0] WriteCount;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  banco_reg_mips dut (
    .clk        (clk),
    .reset      (reset),
    .RegWrite   (RegWrite),
    .ReadReg1   (ReadReg1),
    .ReadReg2   (ReadReg2),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .ReadData1  (ReadData1),
    .ReadData2  (ReadData2),
    .SpOut      (SpOut),
    .WriteCount (WriteCount)
  );

  typedef struct {
    logic        rst;
    logic        rw;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic [31:0] exp_sp;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [8];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  initial begin
    // Each vector is applied before an edge and checked 1 time unit after it.
    vecs[0] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd29, 5'd31, 32'd227,      32'd0,        32'd227,  16'd0};
    vecs[1] = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'd0,        32'd0,        32'd227,  16'd0};
    vecs[2] = '{1'b1, 1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd0,  32'hDEADBEEF, 32'd0,        32'd227,  16'd1};
    vecs[3] = '{1'b1, 1'b1, 5'd0,  32'h1234,     5'd0,  5'd8,  32'd0,        32'hDEADBEEF, 32'd227,  16'd1};
    vecs[4] = '{1'b1, 1'b1, 5'd9,  32'h11,       5'd9,  5'd8,  32'h11,       32'hDEADBEEF, 32'd227,  16'd2};
    vecs[5] = '{1'b1, 1'b1, 5'd29, 32'h400,      5'd29, 5'd9,  32'h400,      32'h11,       32'h400,  16'd3};
    vecs[6] = '{1'b1, 1'b1, 5'd31, 32'hCAFE0001, 5'd31, 5'd31, 32'hCAFE0001, 32'hCAFE0001, 32'h400,  16'd4};
    vecs[7] = '{1'b1, 1'b0, 5'd10, 32'hFFFF,     5'd10, 5'd29, 32'd0,        32'h400,      32'h400,  16'd4};

    reset = 1'b0; RegWrite = 1'b0; WriteReg = 5'd0; WriteData = 32'd0;
    ReadReg1 = 5'd0; ReadReg2 = 5'd0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      reset = vecs[i].rst; RegWrite = vecs[i].rw; WriteReg = vecs[i].wreg;
      WriteData = vecs[i].wdata; ReadReg1 = vecs[i].r1; ReadReg2 = vecs[i].r2;
      @(posedge clk); #1;
      check32($sformatf("vec%0d_rd1", i), ReadData1, vecs[i].exp1);
      check32($sformatf("vec%0d_rd2", i), ReadData2, vecs[i].exp2);
      check32($sformatf("vec%0d_sp", i), SpOut, vecs[i].exp_sp);
      check16($sformatf("vec%0d_cnt", i), WriteCount, vecs[i].exp_cnt);
    end

    // Same-cycle read of the address being written (reg9 holds 0x11).
    @(negedge clk);
    RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'h55; ReadReg2 = 5'd9; ReadReg1 = 5'd29;
    #1;
`ifdef BANCO_REG_BYPASS_EN
    check32("same_cycle_pre", ReadData2, 32'h55);
`else
    check32("same_cycle_pre", ReadData2, 32'h11);
`endif
    @(posedge clk); #1;
    RegWrite = 1'b0;
    #1;
    check32("same_cycle_post", ReadData2, 32'h55);
    check16("same_cycle_cnt", WriteCount, 16'd5);

    // Reset and write on the same edge: reset wins and all state is discarded.
    @(negedge clk);
    reset = 1'b0; RegWrite = 1'b1; WriteReg = 5'd29; WriteData = 32'h100;
    ReadReg1 = 5'd8; ReadReg2 = 5'd31;
    @(posedge clk); #1;
    RegWrite = 1'b0;
    #1;
    check32("rst_vs_wr_sp", SpOut, 32'd227);
    check16("rst_vs_wr_cnt", WriteCount, 16'd0);
    check32("rst_clears_r8", ReadData1, 32'd0);
    check32("rst_ra", ReadData2, 32'd0);

    // Counter wrap: 65536 consecutive writes to reg 3.
    @(negedge clk);
    reset = 1'b1; ReadReg1 = 5'd3;
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      RegWrite = 1'b1; WriteReg = 5'd3; WriteData = i;
      if (i == 65535) begin
        check16("wrap_pre_ffff", WriteCount, 16'hFFFF);
      end else begin
      end
    end
    @(negedge clk);
    RegWrite = 1'b0;
    #1;
    check16("wrap_cnt", WriteCount, 16'd0);
    check32("wrap_r3", ReadData1, 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/banco_reg_mips.md
Name: banco_reg_mips

Overview:
- 32 x 32-bit general-purpose register file of the multicycle MIPS datapath.
- Sits directly downstream of the write-register-select mux; consumes its 5-bit WriteReg address and commits WriteData on the clock edge when the control unit asserts RegWrite.
- Two combinational read ports feed the A/B operand registers.
- Enforces MIPS conventions: $zero is hardwired; $sp and $ra have defined reset values.

Parameters:
- DATA_W, 32, register width in bits
- SP_INIT, 227, reset value of register 29 ($sp)
- RA_INIT, 0, reset value of register 31 ($ra)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk
- RegWrite  input  1  write enable from control unit
- ReadReg1  input  5  read port 1 address (rs)
- ReadReg2  input  5  read port 2 address (rt)
- WriteReg  input  5  write address from write-register-select mux
- WriteData  input  DATA_W  data to store
- ReadData1  output  DATA_W  contents of ReadReg1
- ReadData2  output  DATA_W  contents of ReadReg2
- SpOut  output  DATA_W  current $sp value, for debug/monitor
- WriteCount  output  16  number of committed writes since reset

Behaviour:
- Storage is regs[0..31], DATA_W each.
- Reset:
  - Applies on a rising edge with reset==0.
  - regs[29]=SP_INIT, regs[31]=RA_INIT, all other regs=0, WriteCount=0.
  - Reset has priority over a write in the same cycle; that write is dropped.
  - Reset asserted mid-program discards all state.
- Write:
  - On a rising edge with reset==1, RegWrite==1 and WriteReg!=0: regs[WriteReg] <= WriteData, and WriteCount increments by 1.
  - WriteReg==0 with RegWrite==1 is silently ignored: no state change, no count increment.
  - WriteCount wraps from 0xFFFF to 0x0000.
- X on WriteReg:
  - The upstream mux outputs X for unused selects.
  - If RegWrite==1 and WriteReg contains X/Z, no register is modified.
  - Simulation-only: $error is issued (guarded by translate_off).
- Read:
  - Purely combinational. ReadDataN = (ReadRegN==0) ? 0 : regs[ReadRegN].
  - A read of the address being written in the same cycle returns the OLD value; the new value is visible after the edge, unless the optional feature is enabled.
  - Both ports may address the same register simultaneously.
- SpOut is combinational: regs[29].
- Latency: write commits at the first rising edge with RegWrite==1; read is zero-cycle.
- No handshake. The control FSM guarantees RegWrite is a 1-cycle pulse per write state. A multi-cycle RegWrite produces one write (and one count) per cycle.

Optional Feature:
- Macro BANCO_REG_BYPASS_EN.
- Defined: a write-through bypass. If RegWrite==1, WriteReg!=0 and ReadRegN==WriteReg, then ReadDataN=WriteData in the same cycle. The same rule applies to SpOut when WriteReg==29.
- Undefined: reads return stored values only (old value during a same-cycle write).
- Sequential behaviour is identical in both builds.

Decomposition:
- Shared package mips_pkg holds:
  - localparams REG_ZERO=5'd0, REG_SP=5'd29, REG_RA=5'd31
  - typedef reg_addr_t (logic [4:0])
  - typedef word_t (logic [31:0])
  - The write-select encoding constants shared with the upstream mux: SEL_RT=0, SEL_RD=1, SEL_RS=2, SEL_SP=3, SEL_RA=4.
- Natural sub-module: banco_reg_readport, one combinational read port (zero-guard plus optional bypass), instantiated twice.

Test Plan:
- Reset: hold reset=0 for 1 edge, release -> ReadReg1=29 gives 227; ReadReg2=31 gives 0; reg 5 reads 0; WriteCount=0.
- Write/read: RegWrite=1, WriteReg=8, WriteData=0xDEADBEEF, 1 edge, then ReadReg1=8 -> ReadData1=0xDEADBEEF; WriteCount=1.
- $zero: RegWrite=1, WriteReg=0, WriteData=0x1234 -> ReadData1 (addr 0)=0; WriteCount unchanged.
- Same-cycle read of written address: WriteReg=ReadReg2=9, WriteData=0x55 with reg9=0x11 -> before edge ReadData2=0x11 (no bypass) or 0x55 (BANCO_REG_BYPASS_EN); after edge 0x55 in both builds.
- Reset vs write: reset=0 and RegWrite=1, WriteReg=29, WriteData=0x100 on the same edge -> SpOut=227, WriteCount=0.
- Counter wrap: 65536 writes to reg 3 -> WriteCount=0; reg3 holds the last written value.
